// File: rtl/quadratic_solver.sv
// -----------------------------------------------------------------------------
// quadratic_solver
//
// Searches x = 0..255 for the smallest x with a*x^2 + b*x + c == y (mod 2^16).
// Forward differences replace the multiplier. Each candidate costs one add pair
// per cycle: p tracks the polynomial value and d tracks the first difference.
// A search is started with the inicio/pronto handshake, which is shared with
// the quadratic evaluator.
//
// The file is split into a controller (FSM + pronto) and a datapath
// (coefficient capture, difference engine, result registers).
//
// Ports (top):
//   clock       in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-low reset
//   inicio      in   1   start request, sampled only in IDLE
//   a, b, c     in  16   polynomial coefficients, captured at start
//   y           in  16   target value, captured at start
//   pronto      out  1   one-cycle done pulse (registered)
//   encontrado  out  1   1 = last search found a match (registered)
//   x           out  8   smallest matching x, 0 when not found (registered)
// -----------------------------------------------------------------------------

// Controller: sequences IDLE -> SEARCH -> DONE and owns the pronto flop.
module quadratic_solver_ctrl (
  input  logic clock,
  input  logic reset,
  input  logic inicio,
  input  logic hit,     // p == yr for the current candidate
  input  logic last,    // current candidate is x = 255
  output logic load,    // capture coefficients and seed the difference engine
  output logic step,    // advance to the next candidate
  output logic finish,  // write the search result this edge
  output logic pronto
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t state, state_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pronto <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state  <= state_nxt;
      pronto <= finish;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (inicio) begin
          load      = 1'b1;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        // The equality test wins over the end-of-range test, so a match at
        // x = 255 is reported as found.
        if (hit || last) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// Datapath: forward-difference evaluation of the polynomial at xi.
// Invariants while searching with xi = k:
//   p = a*k^2 + b*k + c,  d = a*(2k+1) + b   (both mod 2^16)
module quadratic_solver_dp (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        finish,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] y,
  output logic        hit,
  output logic        last,
  output logic        encontrado,
  output logic [7:0]  x
);

  logic [15:0] ar;
  logic [15:0] yr;
  logic [15:0] p;
  logic [15:0] d;
  logic [7:0]  xi;
  logic [15:0] a2;

  assign hit  = (p == yr);
  assign last = (xi == 8'hFF);
  // Second difference 2a; the MSB of ar falls off, as the mod-2^16 sums need.
  assign a2   = {ar[14:0], 1'b0};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ar         <= '0;
      yr         <= '0;
      p          <= '0;
      d          <= '0;
      xi         <= '0;
      encontrado <= 1'b0;
      x          <= '0;
    end else begin
      if (load) begin
        ar <= a;
        yr <= y;
        p  <= c;
        d  <= a + b;
        xi <= '0;
      end else if (step) begin
        p  <= p + d;
        d  <= d + a2;
        xi <= xi + 8'd1;
      end
      // Result registers only move on the edge that raises pronto.
      if (finish) begin
        encontrado <= hit;
        x          <= hit ? xi : 8'd0;
      end
    end
  end

endmodule

// Top: wires controller and datapath together.
module quadratic_solver (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] y,
  output logic        pronto,
  output logic        encontrado,
  output logic [7:0]  x
);

  logic load;
  logic step;
  logic finish;
  logic hit;
  logic last;

  quadratic_solver_ctrl u_ctrl (
    .clock  (clock),
    .reset  (reset),
    .inicio (inicio),
    .hit    (hit),
    .last   (last),
    .load   (load),
    .step   (step),
    .finish (finish),
    .pronto (pronto)
  );

  quadratic_solver_dp u_dp (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .finish     (finish),
    .a          (a),
    .b          (b),
    .c          (c),
    .y          (y),
    .hit        (hit),
    .last       (last),
    .encontrado (encontrado),
    .x          (x)
  );

endmodule

// File: tb/tb_quadratic_solver.sv
// -----------------------------------------------------------------------------
// tb_quadratic_solver
//
// Directed-vector bench for quadratic_solver. Expected latencies, roots and
// found flags are hand-computed constants. Inputs change on the falling edge.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_quadratic_solver;

  logic        clock;
  logic        reset;
  logic        inicio;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic [15:0] y;
  logic        pronto;
  logic        encontrado;
  logic [7:0]  x;

  int n_checks;
  int n_pass;

  quadratic_solver dut (
    .clock      (clock),
    .reset      (reset),
    .inicio     (inicio),
    .a          (a),
    .b          (b),
    .c          (c),
    .y          (y),
    .pronto     (pronto),
    .encontrado (encontrado),
    .x          (x)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Drive coefficients and a one-cycle inicio pulse; returns just after E0.
  task automatic start(input logic [15:0] ta, input logic [15:0] tb,
                       input logic [15:0] tc, input logic [15:0] ty);
    @(negedge clock);
    a = ta; b = tb; c = tc; y = ty;
    inicio = 1'b1;
    @(posedge clock);   // E0
    #1;
    inicio = 1'b0;
  endtask

  // One full search. Checks the latency of the first pronto, the result,
  // that x/encontrado did not move before pronto, and that pronto drops.
  task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                     input logic [15:0] tc, input logic [15:0] ty,
                     input int exp_lat, input logic [7:0] exp_x, input logic exp_enc);
    int   lat;
    int   early_moves;
    logic [7:0] x0;
    logic       e0;
    start(ta, tb, tc, ty);
    x0 = x;
    e0 = encontrado;
    lat = 0;
    early_moves = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clock);
      #1;
      if (pronto) begin
        lat = n;
        break;
      end
      if (x !== x0 || encontrado !== e0) early_moves++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " x"}, x, exp_x);
    check({tag, " encontrado"}, encontrado, exp_enc);
    check({tag, " result held before pronto"}, early_moves, 0);
    @(posedge clock);
    #1;
    check({tag, " pronto one cycle"}, pronto, 1'b0);
    check({tag, " x held"}, x, exp_x);
    check({tag, " encontrado held"}, encontrado, exp_enc);
  endtask

  initial begin
    int pulses;
    int lat;
    n_checks = 0;
    n_pass   = 0;
    inicio = 1'b0;
    a = '0; b = '0; c = '0; y = '0;
    reset = 1'b0;

    // Reset state.
    #12;
    check("reset pronto", pronto, 1'b0);
    check("reset x", x, 8'd0);
    check("reset encontrado", encontrado, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Square root: 5^2 = 25.
    run("sqrt25", 16'd1, 16'd0, 16'd0, 16'd25, 6, 8'd5, 1'b1);
    // Immediate hit at x = 0.
    run("immediate", 16'd0, 16'd0, 16'd7, 16'd7, 1, 8'd0, 1'b1);
    // Constant 7 never equals 8: full sweep, not found.
    run("no_solution", 16'd0, 16'd0, 16'd7, 16'd8, 256, 8'd0, 1'b0);
    // 255^2 = 0xFE01, found only at the last candidate.
    run("last_cand", 16'd1, 16'd0, 16'd0, 16'hFE01, 256, 8'd255, 1'b1);
    // 256*k^2 == 0x2400 first at k = 6 (needs truncated ar<<1 and wrapping sums).
    run("wrap", 16'h0100, 16'd0, 16'd0, 16'h2400, 7, 8'd6, 1'b1);
    // 2k^2+3k+1: 1, 6, 15.
    run("mixed", 16'd2, 16'd3, 16'd1, 16'd15, 3, 8'd2, 1'b1);
    // -k^2+2k: 0, 1, 0 ... the first match, x = 1, must be reported.
    run("first_match", 16'hFFFF, 16'd2, 16'd0, 16'd1, 2, 8'd1, 1'b1);

    // Reset mid-search.
    start(16'd0, 16'd0, 16'd7, 16'd8);
    repeat (100) @(posedge clock);   // E0 + 100
    #1;
    check("pre-reset x", x, 8'd1);
    check("pre-reset encontrado", encontrado, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("async reset pronto", pronto, 1'b0);
    check("async reset x", x, 8'd0);
    check("async reset encontrado", encontrado, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clock);
      #1;
      if (pronto) pulses++;
    end
    check("no pronto after abort", pulses, 0);
    check("x after abort", x, 8'd0);

    // Input isolation: y changes mid-search and inicio is pulsed in SEARCH.
    start(16'd1, 16'd0, 16'd0, 16'd25);
    lat = 0;
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (n == 2) y = 16'd36;
      if (n == 3) inicio = 1'b1;
      if (n == 4) inicio = 1'b0;
      if (pronto) begin
        pulses++;
        if (lat == 0) lat = n;
      end
    end
    check("isolation latency", lat, 6);
    check("isolation x", x, 8'd5);
    check("isolation encontrado", encontrado, 1'b1);
    check("isolation single pronto", pulses, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
